// File: rtl/memory_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter slice.
//   - Default parameter values for the top level.
//   - Request kind encoding carried on req_write.
//   - index_bits(): width of a client index. It never returns less than 1 bit.
package memory_port_arbiter_pkg;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_DEPTH      = 512;
  localparam int DEFAULT_REQUESTERS = 2;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_e;

  function automatic int index_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_port_arbiter_mem.sv
// Simple dual-port RAM with one write port and one registered read port.
//   write_clock / write_clock_enable / write_enable / write_addr / write_data
//       Write port. The word is committed at the rising edge.
//   read_clock / read_clock_enable / read_enable / read_addr
//       Read port. read_data updates one cycle after the read is issued.
//   read_data
//       Registered read word. It is not reset.
// A read and a write to the same address on the same edge return the old word.
module dual_port_memory #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 512,
  localparam int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 write_clock,
  input  logic                 write_clock_enable,
  input  logic                 write_enable,
  input  logic [ADDR_BITS-1:0] write_addr,
  input  logic [WIDTH-1:0]     write_data,
  input  logic                 read_clock,
  input  logic                 read_clock_enable,
  input  logic                 read_enable,
  input  logic [ADDR_BITS-1:0] read_addr,
  output logic [WIDTH-1:0]     read_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] read_data_q;

  always_ff @(posedge write_clock) begin
    if (write_clock_enable && write_enable) begin
      mem_q[write_addr] <= write_data;
    end
  end

  // Nonblocking read of the array samples the pre-edge contents.
  // This gives the old-data behaviour on an address collision.
  always_ff @(posedge read_clock) begin
    if (read_clock_enable && read_enable) begin
      read_data_q <= mem_q[read_addr];
    end
  end

  assign read_data = read_data_q;

endmodule

// File: rtl/memory_port_arbiter_rr.sv
// Round-robin arbiter with a registered search pointer.
//   clock, reset  single clock; synchronous active-high reset.
//   request[N]    candidate requests for this port.
//   grant[N]      combinational one-hot grant. It is all-zero while reset is high.
//   grant_index   index of the granted client. It is only meaningful when |grant.
// The search starts at the pointer and wraps upward.
// After a grant to client g the pointer moves to g+1 mod N. With no grant it holds.
module round_robin_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int IDX_W = index_bits(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     request,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_index
);

  logic [IDX_W-1:0] pointer_q;
  logic [IDX_W-1:0] pointer_d;
  logic             found;
  logic [IDX_W:0]   probe_sum;
  logic [IDX_W-1:0] probe;

  always_comb begin
    grant       = '0;
    grant_index = '0;
    found       = 1'b0;
    probe_sum   = '0;
    probe       = '0;
    for (int off = 0; off < N; off++) begin
      // One extra bit keeps pointer + offset from overflowing before the wrap.
      probe_sum = {1'b0, pointer_q} + (IDX_W+1)'(off);
      if (probe_sum >= (IDX_W+1)'(N)) begin
        probe_sum = probe_sum - (IDX_W+1)'(N);
      end
      probe = probe_sum[IDX_W-1:0];
      if (!found && request[probe]) begin
        found        = 1'b1;
        grant[probe] = 1'b1;
        grant_index  = probe;
      end
    end
    if (reset) begin
      grant = '0;
      found = 1'b0;
    end
  end

  always_comb begin
    pointer_d = pointer_q;
    if (found) begin
      pointer_d = (grant_index == IDX_W'(N - 1)) ? '0 : grant_index + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pointer_q <= '0;
    end else begin
      pointer_q <= pointer_d;
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one dual_port_memory between REQUESTERS clients.
// The write port and the read port each have an independent round-robin arbiter.
//   clock, reset  single clock; synchronous active-high reset.
//   req_valid[N]  client i has a pending request.
//   req_write[N]  1 = write, 0 = read. Qualified by req_valid.
//   req_addr      client i address at [i*ADDR_BITS +: ADDR_BITS].
//   req_wdata     client i write data at [i*WIDTH +: WIDTH].
//   req_ready[N]  combinational grant. A transfer happens when valid & ready.
//   resp_valid[N] one-hot. Marks the client owning resp_data this cycle.
//   resp_data     memory read word. It is returned one cycle after the read grant.
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int REQUESTERS = DEFAULT_REQUESTERS,
  localparam int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [REQUESTERS-1:0]           req_valid,
  input  logic [REQUESTERS-1:0]           req_write,
  input  logic [REQUESTERS*ADDR_BITS-1:0] req_addr,
  input  logic [REQUESTERS*WIDTH-1:0]     req_wdata,
  output logic [REQUESTERS-1:0]           req_ready,
  output logic [REQUESTERS-1:0]           resp_valid,
  output logic [WIDTH-1:0]                resp_data
);

  localparam int IDX_W = index_bits(REQUESTERS);

  logic [REQUESTERS-1:0] wr_cand;
  logic [REQUESTERS-1:0] rd_cand;
  logic [REQUESTERS-1:0] wr_grant;
  logic [REQUESTERS-1:0] rd_grant;
  logic [IDX_W-1:0]      wr_index;
  logic [IDX_W-1:0]      rd_index;
  logic [ADDR_BITS-1:0]  addr_arr  [REQUESTERS];
  logic [WIDTH-1:0]      wdata_arr [REQUESTERS];
  logic [REQUESTERS-1:0] resp_valid_q;
  logic [REQUESTERS-1:0] resp_valid_d;

  genvar gi;
  generate
    for (gi = 0; gi < REQUESTERS; gi++) begin : g_client
      assign addr_arr[gi]  = req_addr[gi*ADDR_BITS +: ADDR_BITS];
      assign wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
      assign wr_cand[gi]   = req_valid[gi] && (req_kind_e'(req_write[gi]) == REQ_WRITE);
      assign rd_cand[gi]   = req_valid[gi] && (req_kind_e'(req_write[gi]) == REQ_READ);
    end
  endgenerate

  round_robin_arbiter #(.N(REQUESTERS)) u_wr_arb (
    .clock       (clock),
    .reset       (reset),
    .request     (wr_cand),
    .grant       (wr_grant),
    .grant_index (wr_index)
  );

  round_robin_arbiter #(.N(REQUESTERS)) u_rd_arb (
    .clock       (clock),
    .reset       (reset),
    .request     (rd_cand),
    .grant       (rd_grant),
    .grant_index (rd_index)
  );

  // A client is a write candidate or a read candidate, never both.
  // The two grants therefore never overlap.
  // Both grants are already forced low while reset is high.
  // That also blocks every memory access during reset.
  assign req_ready = wr_grant | rd_grant;

  // The read response tracks the read grant one cycle later.
  // Reset drops anything in flight.
  assign resp_valid_d = rd_grant;

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
    end
  end

  assign resp_valid = resp_valid_q;

  dual_port_memory #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .write_clock        (clock),
    .write_clock_enable (1'b1),
    .write_enable       (|wr_grant),
    .write_addr         (addr_arr[wr_index]),
    .write_data         (wdata_arr[wr_index]),
    .read_clock         (clock),
    .read_clock_enable  (1'b1),
    .read_enable        (|rd_grant),
    .read_addr          (addr_arr[rd_index]),
    .read_data          (resp_data)
  );

endmodule
